// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto a 5-bit LFSR state stream, counts mismatches,
// measures the sequence period and flags an all-zero (stuck) generator.
module lfsr_checker #(
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned ERR_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:0] in_q,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
  output logic [5:0] period,
  output logic       period_valid,
  output logic       stuck
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0] LOCK_TGT = LOCK_CNT[3:0];
  localparam logic [3:0] ERR_TGT  = ERR_LIMIT[3:0];

  // Successor of a generator state.
  function automatic logic [4:0] nxt(input logic [4:0] s);
    return {s[4] ^ s[3], s[2], s[1], s[1] ^ s[4], s[4]};
  endfunction

  logic [1:0] state_q,        state_d;
  logic [4:0] expected_q,     expected_d;
  logic [4:0] anchor_q,       anchor_d;
  logic [3:0] match_cnt_q,    match_cnt_d;
  logic [3:0] miss_cnt_q,     miss_cnt_d;
  logic [5:0] pcnt_q,         pcnt_d;
  logic [5:0] period_q,       period_d;
  logic       period_valid_q, period_valid_d;
  logic [7:0] err_cnt_q,      err_cnt_d;
  logic       err_pulse_q,    err_pulse_d;
  logic       stuck_q,        stuck_d;
  logic       locked_q,       locked_d;

  logic [3:0] match_inc;
  logic [3:0] miss_inc;
  logic [5:0] pcnt_sat;
  logic [7:0] err_sat;

  // Saturating/incremented helper values shared by the next-state logic.
  always_comb begin
    match_inc = match_cnt_q + 4'd1;
    miss_inc  = miss_cnt_q + 4'd1;
    if (pcnt_q == 6'd63) begin
      pcnt_sat = 6'd63;
    end else begin
      pcnt_sat = pcnt_q + 6'd1;
    end
    if (err_cnt_q == 8'd255) begin
      err_sat = 8'd255;
    end else begin
      err_sat = err_cnt_q + 8'd1;
    end
  end

  // Next-state logic: nothing moves unless a valid sample arrives.
  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    anchor_d       = anchor_q;
    match_cnt_d    = match_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    pcnt_d         = pcnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    err_cnt_d      = err_cnt_q;
    err_pulse_d    = 1'b0;
    stuck_d        = stuck_q;

    if (in_valid) begin
      if (in_q == 5'd0) begin
        stuck_d = 1'b1;
      end else begin
        stuck_d = stuck_q;
      end

      case (state_q)
        ST_HUNT: begin
          if (in_q != 5'd0) begin
            expected_d  = nxt(in_q);
            match_cnt_d = 4'd0;
            state_d     = ST_VERIFY;
          end else begin
            state_d = ST_HUNT;
          end
        end

        ST_VERIFY: begin
          if (in_q == expected_q) begin
            match_cnt_d = match_inc;
            expected_d  = nxt(in_q);
            if (match_inc == LOCK_TGT) begin
              state_d        = ST_LOCKED;
              anchor_d       = in_q;
              miss_cnt_d     = 4'd0;
              pcnt_d         = 6'd0;
              period_valid_d = 1'b0;
            end else begin
              state_d = ST_VERIFY;
            end
          end else if (in_q == 5'd0) begin
            state_d = ST_HUNT;
          end else begin
            expected_d  = nxt(in_q);
            match_cnt_d = 4'd0;
            state_d     = ST_VERIFY;
          end
        end

        ST_LOCKED: begin
          if (in_q == expected_q) begin
            miss_cnt_d = 4'd0;
            expected_d = nxt(in_q);
            if (in_q == anchor_q) begin
              period_d       = pcnt_sat;
              period_valid_d = 1'b1;
              pcnt_d         = 6'd0;
            end else begin
              pcnt_d = pcnt_sat;
            end
          end else begin
            // Flywheel: advance from the prediction, never from the bad sample.
            err_pulse_d = 1'b1;
            err_cnt_d   = err_sat;
            miss_cnt_d  = miss_inc;
            expected_d  = nxt(expected_q);
            pcnt_d      = pcnt_sat;
            if (miss_inc >= ERR_TGT) begin
              state_d        = ST_HUNT;
              period_valid_d = 1'b0;
            end else begin
              state_d = ST_LOCKED;
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_HUNT;
      expected_q     <= 5'd0;
      anchor_q       <= 5'd0;
      match_cnt_q    <= 4'd0;
      miss_cnt_q     <= 4'd0;
      pcnt_q         <= 6'd0;
      period_q       <= 6'd0;
      period_valid_q <= 1'b0;
      err_cnt_q      <= 8'd0;
      err_pulse_q    <= 1'b0;
      stuck_q        <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      anchor_q       <= anchor_d;
      match_cnt_q    <= match_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      pcnt_q         <= pcnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      err_cnt_q      <= err_cnt_d;
      err_pulse_q    <= err_pulse_d;
      stuck_q        <= stuck_d;
      locked_q       <= locked_d;
    end
  end

  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign err_cnt      = err_cnt_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stuck        = stuck_q;

endmodule
